// File: rtl/zdet_pkg.sv
// Shared types and constants for the zero-detect arbiter.
package zdet_pkg;

  localparam int OP_W            = 32;
  localparam int DEFAULT_SLICE_W = 8;
  localparam int N_SLICES        = OP_W / DEFAULT_SLICE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Number of scan cycles for a given slice width.
  function automatic int slices_for(input int slice_w);
    return OP_W / slice_w;
  endfunction

endpackage

// File: rtl/zero_slice_or.sv
// Combinational OR-reduction of one operand slice: high when any bit is set.
module zero_slice_or #(
  parameter int W = 8
) (
  input  logic [W-1:0] slice,
  output logic         nz
);

  assign nz = |slice;

endmodule

// File: rtl/zero_detect_arbiter.sv
// Two-requester round-robin arbiter feeding a sliced zero detector.
// Optional ZERO_EARLY_EXIT_EN: finish the scan on the first nonzero slice.
module zero_detect_arbiter
  import zdet_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [OP_W-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [OP_W-1:0] req1_data,
  output logic            req1_ready,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic            rsp_zero,
  input  logic            rsp_ready,
  output logic            busy
);

  localparam int NSL   = slices_for(SLICE_W);
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSL - 1);

  state_t                      state;
  logic [OP_W-1:0]             op_reg;
  logic                        acc;
  logic                        owner;
  logic                        last_grant;
  logic [CNT_W-1:0]            cnt;
  logic [NSL-1:0][SLICE_W-1:0] slices;
  logic [SLICE_W-1:0]          cur_slice;
  logic                        slice_nz;
  logic                        grant0;
  logic                        grant1;
  logic                        scan_done;

  // Viewing op_reg as an array of slices keeps every index inside bit 31.
  assign slices    = op_reg;
  assign cur_slice = slices[cnt];

  zero_slice_or #(.W(SLICE_W)) u_slice_or (
    .slice (cur_slice),
    .nz    (slice_nz)
  );

  // NOTE: grants are gated by reset so every output reads 0 while reset is held,
  // even though the state register only clears on the next edge.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && state == S_IDLE) begin
      grant0 = req0_valid && (!req1_valid ||  last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

`ifdef ZERO_EARLY_EXIT_EN
  assign scan_done = (cnt == LAST_CNT) || slice_nz;
`else
  assign scan_done = (cnt == LAST_CNT);
`endif

  // NOTE: all state, including op_reg, uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_reg     <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            op_reg     <= grant1 ? req1_data : req0_data;
            owner      <= grant1;
            last_grant <= grant1;
            acc        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          acc <= acc | slice_nz;
          cnt <= cnt + 1'b1;
          if (scan_done) begin
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_zero  <= ~(acc | slice_nz);
            rsp_id    <= owner;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_detect_arbiter.sv
// Scoreboard bench: a per-cycle arbitration model predicts grants and results,
// a monitor process compares each presented response against the queue.
module tb_zero_detect_arbiter;
  import zdet_pkg::*;

  localparam int SW = 8;
  localparam int NS = 32 / SW;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_ready, busy;

  logic        r4_valid, r4_ready, r4_ready1, r4_rsp_valid, r4_rsp_id, r4_rsp_zero, r4_busy;
  logic [31:0] r4_data;
  logic        r4_v1 = 1'b0;
  logic [31:0] r4_d1 = 32'h0;
  logic        r4_rsp_ready = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic id;
    logic zero;
    int   edge_no;
  } exp_t;

  exp_t sb[$];
  bit   grant_log[$];

  bit m_ptr       = 1'b1;
  bit m_pending   = 1'b0;
  int m_resp_edge = 0;
  int m_free_from = 0;

  zero_detect_arbiter #(.SLICE_W(SW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_zero   (rsp_zero),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  zero_detect_arbiter #(.SLICE_W(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (r4_valid),
    .req0_data  (r4_data),
    .req0_ready (r4_ready),
    .req1_valid (r4_v1),
    .req1_data  (r4_d1),
    .req1_ready (r4_ready1),
    .rsp_valid  (r4_rsp_valid),
    .rsp_id     (r4_rsp_id),
    .rsp_zero   (r4_rsp_zero),
    .rsp_ready  (r4_rsp_ready),
    .busy       (r4_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Cycles from accept edge to the edge where rsp_valid is first seen.
  function automatic int exp_lat(input logic [31:0] d, input int sw);
    int          n;
    int          lat;
    logic [63:0] m;
    n   = 32 / sw;
    lat = n + 1;
    m   = (64'd1 << sw) - 64'd1;
`ifdef ZERO_EARLY_EXIT_EN
    for (int k = 0; k < n; k++) begin
      if (((64'(d) >> (k * sw)) & m) != 64'd0) begin
        lat = k + 2;
        break;
      end
    end
`else
    if (m == 64'd0 && d == 32'd0) lat = n + 1;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(3))
      0:       return 32'h0;
      1:       return 32'h1 << $urandom_range(31);
      default: return $urandom();
    endcase
  endfunction

  // One clock: model and compare at the negedge, then advance past the posedge.
  task automatic tick();
    int   e;
    bit   idle, g0, g1;
    exp_t x;
    @(negedge clk);
    e = cyc + 1;
    if (reset) begin
      check("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
      m_pending   = 1'b0;
      m_free_from = 0;
      m_ptr       = 1'b1;
      sb.delete();
    end else begin
      idle = !m_pending && (e >= m_free_from);
      g0   = idle && req0_valid && (!req1_valid || m_ptr);
      g1   = idle && req1_valid && (!req0_valid || !m_ptr);
      check("req_ready", {req0_ready, req1_ready}, {g0, g1});
      check("busy", busy, !idle);
      if (m_pending && e >= m_resp_edge && rsp_ready) begin
        m_pending   = 1'b0;
        m_free_from = e + 1;
      end
      if (g0 || g1) begin
        x.id      = g1;
        x.zero    = g1 ? (req1_data == 32'h0) : (req0_data == 32'h0);
        x.edge_no = e + exp_lat(g1 ? req1_data : req0_data, SW);
        sb.push_back(x);
        grant_log.push_back(g1);
        m_pending   = 1'b1;
        m_resp_edge = x.edge_no;
        m_ptr       = g1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t cur;
    bit   holding;
    int   e;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      e = cyc + 1;
      if (reset) begin
        holding = 1'b0;
      end else if (rsp_valid) begin
        if (!holding) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", rsp_valid, 1'b0);
          end else begin
            cur     = sb.pop_front();
            holding = 1'b1;
            check("rsp_id", rsp_id, cur.id);
            check("rsp_zero", rsp_zero, cur.zero);
            check("rsp_latency", e, cur.edge_no);
          end
        end else begin
          check("rsp_id_hold", rsp_id, cur.id);
          check("rsp_zero_hold", rsp_zero, cur.zero);
        end
        if (rsp_ready) holding = 1'b0;
      end else begin
        check("rsp_idle_outputs", {rsp_zero, rsp_id}, 2'b00);
        if (sb.size() > 0 && e > sb[0].edge_no) begin
          check("rsp_timeout", rsp_valid, 1'b1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic set_req(input bit v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
  endtask

  task automatic issue(input bit which, input logic [31:0] d);
    if (which) set_req(1'b0, 32'h0, 1'b1, d);
    else       set_req(1'b1, d, 1'b0, 32'h0);
    tick();
    set_req(1'b0, $urandom(), 1'b0, $urandom());
    repeat (NS + 4) tick();
  endtask

  task automatic run4(input logic [31:0] d);
    int a;
    int n;
    r4_data  = d;
    r4_valid = 1'b1;
    #1;
    check("s4_ready", r4_ready, 1'b1);
    tick();
    r4_valid = 1'b0;
    a = cyc;
    n = 0;
    while (!r4_rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("s4_rsp_valid", r4_rsp_valid, 1'b1);
    check("s4_latency", cyc + 1 - a, exp_lat(d, 4));
    check("s4_zero", r4_rsp_zero, d == 32'h0);
    check("s4_id", r4_rsp_id, 1'b0);
    repeat (3) tick();
  endtask

  initial begin : stimulus
    reset     = 1'b1;
    rsp_ready = 1'b1;
    r4_valid  = 1'b0;
    r4_data   = 32'h0;
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);

    issue(1'b0, 32'h0000_0000);
    issue(1'b1, 32'h8000_0000);
    issue(1'b1, 32'h0000_0001);

    // Both requesters valid continuously: grants must alternate.
    grant_log.delete();
    set_req(1'b1, rand_data(), 1'b1, rand_data());
    repeat (8 * (NS + 2)) begin
      tick();
      req0_data = rand_data();
      req1_data = rand_data();
    end
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (NS + 4) tick();
    check("alt_count", grant_log.size(), 8);
    foreach (grant_log[i]) check("grant_alternate", grant_log[i], i % 2);

    // Consumer stalls for ten cycles while both requesters wait.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_ff00);
    set_req(1'b1, 32'h0, 1'b1, 32'h0);
    repeat (10) tick();
    check("stall_rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) tick();

    // Reset two cycles after an accept, then contention goes to req0.
    set_req(1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_busy", busy, 1'b0);
    grant_log.delete();
    set_req(1'b1, 32'h0000_0010, 1'b1, 32'h0);
    tick();
    check("post_reset_grant", grant_log.size() > 0 ? grant_log[0] : 1'b1, 1'b0);
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (NS + 4) tick();

    // Random traffic with occasional stalls and resets.
    repeat (3000) begin
      set_req($urandom_range(9) < 6, rand_data(), $urandom_range(9) < 6, rand_data());
      rsp_ready = $urandom_range(3) != 0;
      reset     = $urandom_range(299) == 0;
      tick();
    end
    reset     = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (NS + 6) tick();
    check("sb_drained", sb.size(), 0);

    run4(32'h0010_0000);
    run4(32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
